// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one register bank + ALU among NREQ requesters (IDLE->DEC->EXE->WB).
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module alu_req_sched #(
    parameter int NREQ   = 2,
    parameter int INS_W  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*INS_W-1:0]   req_ins,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [3:0]              alu_op,
    output logic [ADDR_W-1:0]       rf_rs1,
    output logic [ADDR_W-1:0]       rf_rs2,
    output logic [ADDR_W-1:0]       rf_rd,
    output logic                    rf_wr_en,
    input  logic [DATA_W-1:0]       alu_out,
    output logic                    busy
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, DEC, EXE, WB} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] base_ptr;
    logic             grant_vld;
    logic [INS_W-1:0] grant_ins;
    logic             accept;

`ifdef ARB_FIXED_PRIO_EN
    assign base_ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr;

    // The requester after the one just served gets first look next time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
        end
    end

    assign base_ptr = rr_ptr;
`endif

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PTR_W'((int'(base_ptr) + k) % NREQ);
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant     = scan_idx;
            end
        end
    end

    assign grant_ins = req_ins[int'(grant)*INS_W +: INS_W];
    assign accept    = (state == IDLE) && grant_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is gated by reset so nothing appears accepted while the block is held in reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        rf_wr_en  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = rst;
                    state_nxt        = DEC;
                end
            end
            DEC: state_nxt = EXE;
            EXE: state_nxt = WB;
            WB: begin
                rf_wr_en         = 1'b1;
                rsp_valid[owner] = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction fields are captured only on acceptance and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_op   <= '0;
            rf_rs1   <= '0;
            rf_rs2   <= '0;
            rf_rd    <= '0;
            owner    <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                alu_op <= grant_ins[15:12];
                rf_rs1 <= {{(ADDR_W-4){1'b0}}, grant_ins[11:8]};
                rf_rs2 <= {{(ADDR_W-4){1'b0}}, grant_ins[7:4]};
                rf_rd  <= {{(ADDR_W-4){1'b0}}, grant_ins[3:0]};
                owner  <= grant;
            end
            if (state == EXE) begin
                rsp_data <= alu_out;
            end
        end
    end

endmodule
